// File: rtl/chls_bus_pkg.sv
// Shared types and constants for the CHLS 8051 external-bus front end.
package chls_bus_pkg;

    typedef enum logic {
        NO_ADDR,
        ADDR_OK
    } bus_state_e;

    // Pin levels while the CPU is idle; sync chains reset to these.
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic ALE_IDLE  = 1'b0;
    localparam logic R_N_IDLE  = 1'b1;
    localparam logic W_N_IDLE  = 1'b1;

    function automatic int unsigned addr_w(input int unsigned ahi_w, input int unsigned data_w);
        return ahi_w + data_w;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flop chain bringing an asynchronous pin group into the clk domain.
module bus_sync #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {STAGES{RST_VAL}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cpu_bus_if.sv
// 8051 external-bus slave front end: synchronised pins, ALE address latch,
// single-cycle write strobe and latency-matched read-back path.
module cpu_bus_if
    import chls_bus_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned AHI_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1,
    parameter bit          AUTO_INC    = 1'b0,
    localparam int unsigned ADDR_W     = addr_w(AHI_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic [AHI_W-1:0]  abus,
    input  logic              ale,
    input  logic              r_n,
    input  logic              w_n,
    input  logic [DATA_W-1:0] dbus_in,
    output logic [DATA_W-1:0] dbus_out,
    output logic              dbus_oe,
    output logic              wr_en_n,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err
);

    logic cs_n_s, ale_s, r_n_s, w_n_s;
    logic [AHI_W-1:0]  abus_s;
    logic [DATA_W-1:0] dbus_s;

    bus_sync #(
        .WIDTH   (4),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({CS_N_IDLE, ALE_IDLE, R_N_IDLE, W_N_IDLE})
    ) u_sync_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({cs_n, ale, r_n, w_n}),
        .q     ({cs_n_s, ale_s, r_n_s, w_n_s})
    );

    // Same depth as the strobes so address/data line up with the detected edge.
    bus_sync #(
        .WIDTH   (ADDR_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({abus, dbus_in}),
        .q     ({abus_s, dbus_s})
    );

    bus_state_e        state_q, state_d;
    logic              ale_prev_q, r_n_prev_q, w_n_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              wr_en_n_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q, dbus_out_q;
    logic              rd_req_q, dbus_oe_q;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic ale_fall, w_rise, r_fall, rd_go, rd_capture;

    always_comb begin
        ale_fall   = ~cs_n_s & ale_prev_q & ~ale_s;
        w_rise     = ~cs_n_s & ~w_n_prev_q & w_n_s;
        r_fall     = ~cs_n_s & r_n_prev_q & ~r_n_s;
        // A write wins over a read arriving in the same cycle.
        rd_go      = r_fall & ~w_rise;
        rd_capture = rd_pipe_q[RD_LAT-1];
        rd_pipe_d  = (rd_pipe_q << 1) | RD_LAT'(rd_req_q);

        state_d = state_q;
        if (ale_fall) begin
            state_d = ADDR_OK;
        end

        err_d = err_q;
        if (((w_rise || r_fall) && state_q == NO_ADDR) || (w_rise && r_fall)) begin
            err_d = 1'b1;
        end

        addr_d = addr_q;
        if (ale_fall) begin
            addr_d = {abus_s, dbus_s};
        end else if (AUTO_INC && (w_rise || rd_go)) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NO_ADDR;
            ale_prev_q <= ALE_IDLE;
            r_n_prev_q <= R_N_IDLE;
            w_n_prev_q <= W_N_IDLE;
            addr_q     <= '0;
            err_q      <= 1'b0;
            wr_en_n_q  <= 1'b1;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_pipe_q  <= '0;
            dbus_out_q <= '0;
            dbus_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ale_prev_q <= ale_s;
            r_n_prev_q <= r_n_s;
            w_n_prev_q <= w_n_s;
            addr_q     <= addr_d;
            err_q      <= err_d;
            wr_en_n_q  <= ~w_rise;
            if (w_rise) begin
                wr_addr_q <= addr_q;
                wr_data_q <= dbus_s;
            end
            rd_req_q <= rd_go;
            if (rd_go) begin
                rd_addr_q <= addr_q;
            end
            rd_pipe_q <= rd_pipe_d;
            if (rd_capture) begin
                dbus_out_q <= rd_data;
            end
            // A late read completes internally but never drives the bus once deselected.
            if (cs_n_s || r_n_s) begin
                dbus_oe_q <= 1'b0;
            end else if (rd_capture) begin
                dbus_oe_q <= 1'b1;
            end
        end
    end

    assign dbus_out = dbus_out_q;
    assign dbus_oe  = dbus_oe_q;
    assign wr_en_n  = wr_en_n_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign err      = err_q;

endmodule
